ram_fill_clr: RTL and testbench
===============================

// Module: ram_fill_clr
//
// PURPOSE
//  Parametrised single-port buffer RAM, the successor of the fixed 16-bit RAM block.
//  - Adds per-word valid tracking, a fill COUNT and a FULL flag.
//  - Adds a sequenced clear (one word per cycle, reported on BUSY) and an optional auto-clear on full.
//  - Sits between the sample/spike front-end, which writes, and the readout logic, which reads and clears.
//
// PARAMETERS
//  DATA_WIDTH  16  word width in bits
//  ADDR_WIDTH  4   address width; DEPTH = 2**ADDR_WIDTH words
//  AUTO_CLR    0   1: start a clear automatically on the cycle after FULL rises
//
// PORTS
//  CLK    in   1             clock, rising edge
//  RST    in   1             reset, asynchronous, active-high
//  EN     in   1             access enable
//  WE     in   1             write when EN=1; read when EN=1 and WE=0
//  CLR    in   1             clear request; single-cycle pulse is sufficient
//  A      in   ADDR_WIDTH    word address
//  Di     in   DATA_WIDTH    write data
//  Do     out  DATA_WIDTH    registered read data
//  DV     out  1             Do valid strobe, high for one cycle per accepted read
//  FULL   out  1             every word written since the last clear or reset
//  COUNT  out  ADDR_WIDTH+1  number of distinct valid words, 0..DEPTH
//  BUSY   out  1             clear sweep in progress; accesses are ignored
//
// BEHAVIOUR
//  Reset (async, RST=1):
//  - Do=0, DV=0, FULL=0, COUNT=0, BUSY=0, all valid bits=0, FSM=IDLE.
//  - Array contents are not reset; invalid words read as 0 (see reads).
//  FSM states: IDLE and CLEAR.
//  - IDLE -> CLEAR on CLR=1, or when AUTO_CLR=1 and FULL is high on the previous cycle.
//  - On entry to CLEAR: COUNT<=0, FULL<=0, BUSY<=1, sweep pointer<=0.
//  - In CLEAR, each cycle: RAM[ptr]<=0, valid[ptr]<=0, ptr++.
//  - After writing ptr=DEPTH-1 -> IDLE, BUSY<=0. The sweep takes exactly DEPTH cycles of BUSY.
//  Writes (IDLE, EN=1, WE=1):
//  - RAM[A]<=Di on the edge.
//  - If valid[A]=0: valid[A]<=1 and COUNT++. If valid[A]=1: overwrite, COUNT unchanged.
//  - FULL<=1 on the same edge at which COUNT reaches DEPTH.
//  Reads (IDLE, EN=1, WE=0):
//  - Do<= valid[A] ? RAM[A] : 0, and DV<=1; 1-cycle latency.
//  - Do holds its value when no read occurs; DV=0 otherwise.
//  Ignored inputs:
//  - EN, WE, A and Di are ignored while BUSY=1: no write, DV=0, Do held.
//  - CLR is also ignored while BUSY=1; the sweep is not restarted.
//  Simultaneous events:
//  - CLR=1 with EN&WE=1 in IDLE: the clear wins and the write is dropped.
//  - CLR=1 with a read: the read is dropped and DV=0.
//  - AUTO_CLR=1: FULL is high for exactly one cycle, and a write in that cycle is dropped (the clear is entered).
//  - AUTO_CLR=0: FULL stays high until CLR.
//  Wrap and overflow:
//  - A wraps naturally within DEPTH.
//  - COUNT never exceeds DEPTH; writes while FULL=1 are accepted as overwrites.
//  Reset mid-sweep: returns to IDLE immediately; valid bits=0, so stale data reads as 0.
//
// STRUCTURE
//  - Shared package: the FSM state encoding (ST_IDLE, ST_CLEAR) and a clog2 helper for COUNT width.
//  - Sub-module ram_sp_core (plain DATA_WIDTH x DEPTH single-port array, sync write, registered read).
//  - Valid bits, COUNT, FULL, the FSM and the read masking live in ram_fill_clr.
//
// TESTING (DATA_WIDTH=16, ADDR_WIDTH=2)
//  1. Reset with RST=1 asynchronously mid-cycle -> all outputs 0 at once; reading A=2 -> Do=0000, DV=1 one cycle later.
//  2. Write 0001..0004 to A=0..3 -> COUNT 1,2,3,4; FULL=1 on the 4th edge; read A=1 -> Do=0002.
//  3. Write A=1 twice (0005, then 0006) -> COUNT=1 after both, read returns 0006.
//  4. FULL then CLR pulse -> BUSY=1 for exactly 4 cycles; COUNT=0, FULL=0; writes during BUSY are lost; every read after BUSY falls -> 0000.
//  5. CLR with EN=WE=1, A=0, Di=BEEF in the same cycle -> write dropped; after the sweep, read A=0 -> 0000, COUNT=0.
//  6. AUTO_CLR=1, fill 4 words -> FULL high for 1 cycle, BUSY rises the next cycle for 4 cycles, COUNT=0 afterwards.

Source files
------------

// File: rtl/ram_fill_clr_pkg.sv
// Shared types for the fill-tracking buffer RAM: FSM encoding and a width helper.
package ram_fill_clr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_fill_clr_if.sv
// Access/status bundle between a client (master) and the fill-tracking RAM (slave).
interface ram_fill_clr_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    localparam int CNT_W = ram_fill_clr_pkg::clog2((1 << ADDR_WIDTH) + 1);

    logic                  en;
    logic                  we;
    logic                  clr;
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] di;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dv;
    logic                  full;
    logic [CNT_W-1:0]      count;
    logic                  busy;

    modport master (output en, we, clr, a, di, input dout, dv, full, count, busy);
    modport slave  (input en, we, clr, a, di, output dout, dv, full, count, busy);
endinterface

// File: rtl/ram_sp_core.sv
// Plain single-port array: synchronous write, registered read (1 cycle); write has priority.
module ram_sp_core #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [(1 << ADDR_WIDTH)];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/ram_fill_clr.sv
// Buffer RAM with per-word valid bits, fill count/full flag and a one-word-per-cycle clear sweep.
// Reads return data one cycle later; all accesses are ignored while the sweep runs (busy).
module ram_fill_clr
    import ram_fill_clr_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter bit AUTO_CLR   = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    ram_fill_clr_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = clog2(DEPTH + 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DEPTH-1:0]      valid;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  busy;
    logic                  dv;
    logic                  rd_vld;

    logic                  start_clr;
    logic                  acc_wr;
    logic                  acc_rd;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic [DATA_WIDTH-1:0] core_rdata;

    // A clear request outranks any access presented in the same cycle.
    assign start_clr  = (state == ST_IDLE) && (bus.clr || (AUTO_CLR && full));
    assign acc_wr     = (state == ST_IDLE) && !start_clr && bus.en && bus.we;
    assign acc_rd     = (state == ST_IDLE) && !start_clr && bus.en && !bus.we;
    assign core_we    = (state == ST_CLEAR) || acc_wr;
    assign core_addr  = (state == ST_CLEAR) ? ptr : bus.a;
    assign core_wdata = (state == ST_CLEAR) ? '0 : bus.di;

    ram_sp_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .re    (acc_rd),
        .addr  (core_addr),
        .wdata (core_wdata),
        .rdata (core_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            valid  <= '0;
            count  <= '0;
            full   <= 1'b0;
            busy   <= 1'b0;
            dv     <= 1'b0;
            rd_vld <= 1'b0;
        end else begin
            dv <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_clr) begin
                        state <= ST_CLEAR;
                        count <= '0;
                        full  <= 1'b0;
                        busy  <= 1'b1;
                        ptr   <= '0;
                    end else if (acc_wr) begin
                        if (!valid[bus.a]) begin
                            valid[bus.a] <= 1'b1;
                            count        <= count + CNT_W'(1);
                            if (count == CNT_W'(DEPTH - 1)) full <= 1'b1;
                        end
                    end else if (acc_rd) begin
                        dv     <= 1'b1;
                        rd_vld <= valid[bus.a];
                    end
                end
                ST_CLEAR: begin
                    valid[ptr] <= 1'b0;
                    ptr        <= ptr + ADDR_WIDTH'(1);
                    if (ptr == '1) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Words never written since the last clear read back as zero.
    assign bus.dout  = rd_vld ? core_rdata : '0;
    assign bus.dv    = dv;
    assign bus.full  = full;
    assign bus.count = count;
    assign bus.busy  = busy;
endmodule

// File: tb/tb_ram_fill_clr.sv
// Directed bench for ram_fill_clr with a 4-word array, plain and auto-clear variants.
module tb_ram_fill_clr;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ram_fill_clr_if #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) bus_m ();
    ram_fill_clr_if #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) bus_a ();

    ram_fill_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .AUTO_CLR(1'b0)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m.slave)
    );

    ram_fill_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .AUTO_CLR(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, return at the following falling edge.
    task automatic step(input bit sel, input logic e, input logic w, input logic c,
                        input logic [1:0] ad, input logic [15:0] d);
        if (!sel) begin
            bus_m.en = e; bus_m.we = w; bus_m.clr = c; bus_m.a = ad; bus_m.di = d;
        end else begin
            bus_a.en = e; bus_a.we = w; bus_a.clr = c; bus_a.a = ad; bus_a.di = d;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        bus_m.en = 0; bus_m.we = 0; bus_m.clr = 0; bus_m.a = 0; bus_m.di = 0;
        bus_a.en = 0; bus_a.we = 0; bus_a.clr = 0; bus_a.a = 0; bus_a.di = 0;

        // 1. asynchronous reset mid-cycle
        #12 rst = 1'b1;
        #1;
        chk("rst_dout",  bus_m.dout,  32'h0);
        chk("rst_dv",    bus_m.dv,    32'h0);
        chk("rst_full",  bus_m.full,  32'h0);
        chk("rst_count", bus_m.count, 32'h0);
        chk("rst_busy",  bus_m.busy,  32'h0);
        chk("rst_count_auto", bus_a.count, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 1, 0, 0, 2'd2, 16'h0);
        chk("rd_unwritten_dv",   bus_m.dv,   32'h1);
        chk("rd_unwritten_dout", bus_m.dout, 32'h0);

        // 2. fill all four words
        step(0, 1, 1, 0, 2'd0, 16'h0001);
        chk("fill_count1", bus_m.count, 32'd1);
        chk("fill_dv_on_write", bus_m.dv, 32'h0);
        step(0, 1, 1, 0, 2'd1, 16'h0002);
        chk("fill_count2", bus_m.count, 32'd2);
        step(0, 1, 1, 0, 2'd2, 16'h0003);
        chk("fill_count3", bus_m.count, 32'd3);
        chk("fill_full3",  bus_m.full,  32'h0);
        step(0, 1, 1, 0, 2'd3, 16'h0004);
        chk("fill_count4", bus_m.count, 32'd4);
        chk("fill_full4",  bus_m.full,  32'h1);
        step(0, 1, 0, 0, 2'd1, 16'h0);
        chk("fill_rd_dv",   bus_m.dv,   32'h1);
        chk("fill_rd_dout", bus_m.dout, 32'h0002);
        step(0, 0, 0, 0, 2'd0, 16'h0);
        chk("idle_dv",        bus_m.dv,   32'h0);
        chk("idle_dout_hold", bus_m.dout, 32'h0002);
        chk("full_sticky",    bus_m.full, 32'h1);

        // 4. clear pulse: busy for 4 cycles, accesses during busy lost
        step(0, 0, 0, 1, 2'd0, 16'h0);
        chk("clr_busy0", bus_m.busy,  32'h1);
        chk("clr_count", bus_m.count, 32'h0);
        chk("clr_full",  bus_m.full,  32'h0);
        step(0, 1, 1, 0, 2'd1, 16'hBEEF);
        chk("clr_busy1", bus_m.busy, 32'h1);
        step(0, 1, 1, 1, 2'd2, 16'hBEEF);
        chk("clr_busy2", bus_m.busy, 32'h1);
        step(0, 1, 1, 0, 2'd3, 16'hBEEF);
        chk("clr_busy3", bus_m.busy, 32'h1);
        step(0, 1, 0, 0, 2'd0, 16'h0);
        chk("clr_busy_fall", bus_m.busy, 32'h0);
        chk("clr_rd_ignored_dv", bus_m.dv, 32'h0);
        chk("clr_count_after", bus_m.count, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 2'(i), 16'h0);
            chk("clr_rd_dout", bus_m.dout, 32'h0);
            chk("clr_rd_dv",   bus_m.dv,   32'h1);
        end

        // 3. overwrite does not bump the count
        step(0, 1, 1, 0, 2'd1, 16'h0005);
        chk("ow_count1", bus_m.count, 32'd1);
        step(0, 1, 1, 0, 2'd1, 16'h0006);
        chk("ow_count2", bus_m.count, 32'd1);
        step(0, 1, 0, 0, 2'd1, 16'h0);
        chk("ow_rd_dout", bus_m.dout, 32'h0006);

        // 5. clear with a simultaneous write: write dropped
        step(0, 1, 1, 1, 2'd0, 16'hBEEF);
        chk("cw_busy",  bus_m.busy,  32'h1);
        chk("cw_count", bus_m.count, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 2'd0, 16'h0);
        chk("cw_busy_fall", bus_m.busy, 32'h0);
        step(0, 1, 0, 0, 2'd0, 16'h0);
        chk("cw_rd_dout", bus_m.dout, 32'h0);
        chk("cw_count_after", bus_m.count, 32'h0);
        step(0, 1, 0, 0, 2'd1, 16'h0);
        chk("cw_rd_stale", bus_m.dout, 32'h0);

        // clear with a simultaneous read: read dropped
        step(0, 1, 0, 1, 2'd1, 16'h0);
        chk("cr_dv",   bus_m.dv,   32'h0);
        chk("cr_busy", bus_m.busy, 32'h1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 2'd0, 16'h0);
        chk("cr_busy_fall", bus_m.busy, 32'h0);

        // 6. auto-clear on full
        step(1, 1, 1, 0, 2'd0, 16'h1111);
        step(1, 1, 1, 0, 2'd1, 16'h2222);
        step(1, 1, 1, 0, 2'd2, 16'h3333);
        chk("ac_count3", bus_a.count, 32'd3);
        step(1, 1, 1, 0, 2'd3, 16'h4444);
        chk("ac_full",   bus_a.full,  32'h1);
        chk("ac_count4", bus_a.count, 32'd4);
        chk("ac_busy0",  bus_a.busy,  32'h0);
        step(1, 1, 1, 0, 2'd0, 16'hDEAD);
        chk("ac_full_drop", bus_a.full,  32'h0);
        chk("ac_busy1",     bus_a.busy,  32'h1);
        chk("ac_count0",    bus_a.count, 32'h0);
        step(1, 0, 0, 0, 2'd0, 16'h0);
        step(1, 0, 0, 0, 2'd0, 16'h0);
        step(1, 0, 0, 0, 2'd0, 16'h0);
        chk("ac_busy4", bus_a.busy, 32'h1);
        step(1, 0, 0, 0, 2'd0, 16'h0);
        chk("ac_busy_fall", bus_a.busy,  32'h0);
        chk("ac_count_end", bus_a.count, 32'h0);
        step(1, 1, 0, 0, 2'd0, 16'h0);
        chk("ac_rd_dout", bus_a.dout, 32'h0);
        chk("ac_rd_dv",   bus_a.dv,   32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
